// File: rtl/xbus_master.sv
// xbus_master: single-outstanding peripheral bus initiator.
// Accepts one read/write command on a valid/ready port. It drives the
// addr/sel/we/data_to_wr bus for 1+WAIT_CYC cycles and samples the decoder
// read mux on the last select cycle. It then returns the result on a
// valid/ready response port.
//
// Optional feature macro: XBUS_TRAP_EN
//   defined   - trap_sel is tracked per access and reported as rsp_err.
//   undefined - trap_sel is ignored and rsp_err is always 0.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. The initiator keeps valid and its payload
// stable until that edge. ready may be low for any number of cycles.
// Here cmd_ready is high only in IDLE. rsp_valid is high only in RESP.

module xbus_master #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // peripheral bus
  output logic [ADDR_W-1:0] addr,
  output logic              sel,
  output logic              we,
  output logic [DATA_W-1:0] data_to_wr,
  input  logic [DATA_W-1:0] data_to_rd,
  input  logic              trap_sel,
  // debug: current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       wr_latched;
  logic       trap_hit;
  logic       err_now;

  assign fsm_state = state;

`ifdef XBUS_TRAP_EN
  // The trap is sticky across the access, so include this cycle's trap_sel.
  assign err_now = trap_hit | trap_sel;
`else
  // Trap reporting is disabled. Both signals exist only to keep one code path.
  logic [1:0] unused_trap;
  assign unused_trap = {trap_sel, trap_hit};
  assign err_now     = 1'b0;
`endif

  // Main transaction FSM; all port and bus outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      addr       <= '0;
      sel        <= 1'b0;
      we         <= 1'b0;
      data_to_wr <= '0;
      wait_cnt   <= 4'd0;
      wr_latched <= 1'b0;
      trap_hit   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state      <= S_ACCESS;
            cmd_ready  <= 1'b0;
            sel        <= 1'b1;
            we         <= cmd_we;
            wr_latched <= cmd_we;
            addr       <= cmd_addr;
            data_to_wr <= cmd_wdata;
            wait_cnt   <= 4'(WAIT_CYC);
            trap_hit   <= 1'b0;
          end else begin
            // cmd_ready stays low for one cycle after reset release.
            cmd_ready <= 1'b1;
          end
        end

        S_ACCESS: begin
          // The write strobe is one cycle only, so the target sees one write.
          we       <= 1'b0;
          trap_hit <= err_now;
          if (wait_cnt == 4'd0) begin
            sel       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= err_now;
            rsp_rdata <= (wr_latched || err_now) ? '0 : data_to_rd;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            // Ready right away so that back-to-back commands are 3+WAIT_CYC apart.
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          sel       <= 1'b0;
          we        <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_master.sv
// tb_xbus_master: directed bench for xbus_master.
// dut uses WAIT_CYC=1 and dut0 uses WAIT_CYC=0. Build with +define+XBUS_TRAP_EN
// to check the trap-reporting variant.

module tb_xbus_master;

  localparam int AW = 12;
  localparam int DW = 32;

`ifdef XBUS_TRAP_EN
  localparam logic        TRAP_ERR   = 1'b1;
  localparam logic [31:0] TRAP_RDATA = 32'h0;
`else
  localparam logic        TRAP_ERR   = 1'b0;
  localparam logic [31:0] TRAP_RDATA = 32'h55;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dut (WAIT_CYC=1) signals ----------------
  logic          cmd_valid = 0, cmd_we = 0, rsp_ready = 0, trap_sel = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0, data_to_rd = '0;
  logic          cmd_ready, rsp_valid, rsp_err, sel, we;
  logic [DW-1:0] rsp_rdata, data_to_wr;
  logic [AW-1:0] addr;
  logic [1:0]    fsm_state;

  // ---------------- dut0 (WAIT_CYC=0) signals ----------------
  logic          cmd_valid_0 = 0, cmd_we_0 = 0, rsp_ready_0 = 0, trap_sel_0 = 0;
  logic [AW-1:0] cmd_addr_0 = '0;
  logic [DW-1:0] cmd_wdata_0 = '0, data_to_rd_0 = '0;
  logic          cmd_ready_0, rsp_valid_0, rsp_err_0, sel_0, we_0;
  logic [DW-1:0] rsp_rdata_0, data_to_wr_0;
  logic [AW-1:0] addr_0;
  logic [1:0]    fsm_state_0;

  int n_checks = 0;
  int n_errors = 0;

  xbus_master #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .addr(addr), .sel(sel), .we(we),
    .data_to_wr(data_to_wr), .data_to_rd(data_to_rd), .trap_sel(trap_sel),
    .fsm_state(fsm_state)
  );

  xbus_master #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid_0), .cmd_ready(cmd_ready_0), .cmd_we(cmd_we_0),
    .cmd_addr(cmd_addr_0), .cmd_wdata(cmd_wdata_0),
    .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready_0), .rsp_rdata(rsp_rdata_0),
    .rsp_err(rsp_err_0), .addr(addr_0), .sel(sel_0), .we(we_0),
    .data_to_wr(data_to_wr_0), .data_to_rd(data_to_rd_0), .trap_sel(trap_sel_0),
    .fsm_state(fsm_state_0)
  );

  // ---------------- driver tasks ----------------
  // All tasks start and end 1ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cmd_ready, then presents one command for one edge.
  // Returns just after the handshake edge N.
  task automatic start_cmd(input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Consumes a pending response on dut.
  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_err, sel, we} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: {cmd_ready,rsp_valid,rsp_err,sel,we}=%b required 00000",
               {cmd_ready, rsp_valid, rsp_err, sel, we});
    end
    n_checks++;
    if ({rsp_rdata, data_to_wr, addr} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: rdata=%h wdata=%h addr=%h required all 0",
               rsp_rdata, data_to_wr, addr);
    end
    n_checks++;
    if (fsm_state !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_state: state=%0d required 0", fsm_state);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release_ready: cmd_ready=%b required 0", cmd_ready);
    end
    tick();
    n_checks++;
    if ({cmd_ready, cmd_ready_0} !== 2'b11) begin
      n_errors++;
      $display("FAIL reset_first_edge_ready: {cmd_ready,cmd_ready_0}=%b required 11",
               {cmd_ready, cmd_ready_0});
    end
  endtask

  task automatic test_write();
    data_to_rd = 32'h12345678;
    start_cmd(1'b1, 12'h010, 32'hDEADBEEF);
    n_checks++;
    if ({sel, we, cmd_ready, rsp_valid} !== 4'b1100) begin
      n_errors++;
      $display("FAIL wr_cycle1: {sel,we,cmd_ready,rsp_valid}=%b required 1100",
               {sel, we, cmd_ready, rsp_valid});
    end
    n_checks++;
    if (addr !== 12'h010 || data_to_wr !== 32'hDEADBEEF || fsm_state !== 2'd1) begin
      n_errors++;
      $display("FAIL wr_bus: addr=%h wdata=%h state=%0d required 010 deadbeef 1",
               addr, data_to_wr, fsm_state);
    end
    tick();
    n_checks++;
    if ({sel, we, cmd_ready, rsp_valid} !== 4'b1000) begin
      n_errors++;
      $display("FAIL wr_cycle2: {sel,we,cmd_ready,rsp_valid}=%b required 1000",
               {sel, we, cmd_ready, rsp_valid});
    end
    tick();
    n_checks++;
    if ({sel, we, cmd_ready, rsp_valid} !== 4'b0001) begin
      n_errors++;
      $display("FAIL wr_rsp_timing: {sel,we,cmd_ready,rsp_valid}=%b required 0001",
               {sel, we, cmd_ready, rsp_valid});
    end
    n_checks++;
    if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_rsp_data: rdata=%h err=%b required 0 0", rsp_rdata, rsp_err);
    end
    finish_rsp();
    n_checks++;
    if ({sel, we, cmd_ready, rsp_valid} !== 4'b0010) begin
      n_errors++;
      $display("FAIL wr_after_rsp: {sel,we,cmd_ready,rsp_valid}=%b required 0010",
               {sel, we, cmd_ready, rsp_valid});
    end
    n_checks++;
    if (addr !== 12'h010 || data_to_wr !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL wr_bus_hold: addr=%h wdata=%h required 010 deadbeef", addr, data_to_wr);
    end
  endtask

  task automatic test_read();
    data_to_rd = 32'h0;
    start_cmd(1'b0, 12'h024, 32'hFFFFFFFF);
    data_to_rd = 32'h5A5A5A5A;
    n_checks++;
    if ({sel, we} !== 2'b10) begin
      n_errors++;
      $display("FAIL rd_cycle1: {sel,we}=%b required 10", {sel, we});
    end
    tick();
    data_to_rd = 32'h000000A5;
    n_checks++;
    if (sel !== 1'b1) begin
      n_errors++;
      $display("FAIL rd_cycle2_sel: sel=%b required 1", sel);
    end
    tick();
    data_to_rd = 32'hFFFF0000;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h000000A5 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_capture: valid=%b rdata=%h err=%b required 1 000000a5 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h000000A5) begin
      n_errors++;
      $display("FAIL rd_hold: valid=%b rdata=%h required 1 000000a5", rsp_valid, rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    int n;
    n = 0;
    rsp_ready_0  = 1'b1;
    data_to_rd_0 = 32'hCAFE0001;
    while (cmd_ready_0 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (cmd_ready_0 !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_ready_timeout: cmd_ready_0=%b required 1", cmd_ready_0);
    end
    cmd_valid_0 = 1'b1;
    cmd_we_0    = 1'b0;
    cmd_addr_0  = 12'h100;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp = {(k % 3 == 0), (k % 3 == 2), (k % 3 == 1)};
      if (k == 8) cmd_valid_0 = 1'b0;
      n_checks++;
      if ({sel_0, cmd_ready_0, rsp_valid_0} !== exp) begin
        n_errors++;
        $display("FAIL b2b_cycle%0d: {sel,cmd_ready,rsp_valid}=%b required %b",
                 k, {sel_0, cmd_ready_0, rsp_valid_0}, exp);
      end
      if (k % 3 == 1) begin
        n_checks++;
        if (rsp_rdata_0 !== 32'hCAFE0001) begin
          n_errors++;
          $display("FAIL b2b_rdata%0d: rdata=%h required cafe0001", k, rsp_rdata_0);
        end
      end
    end
    tick();
    n_checks++;
    if ({sel_0, rsp_valid_0, cmd_ready_0} !== 3'b001) begin
      n_errors++;
      $display("FAIL b2b_stop: {sel,rsp_valid,cmd_ready}=%b required 001",
               {sel_0, rsp_valid_0, cmd_ready_0});
    end
  endtask

  task automatic test_backpressure();
    rsp_ready  = 1'b0;
    data_to_rd = 32'h00000077;
    start_cmd(1'b0, 12'h030, 32'h0);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 12'h0AB;
    tick();
    n_checks++;
    if (addr !== 12'h030) begin
      n_errors++;
      $display("FAIL bp_addr_latched: addr=%h required 030", addr);
    end
    tick();
    data_to_rd = 32'hBAD0BAD0;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if ({rsp_valid, cmd_ready, sel} !== 3'b100 || rsp_rdata !== 32'h77) begin
        n_errors++;
        $display("FAIL bp_stall%0d: {rsp_valid,cmd_ready,sel}=%b rdata=%h required 100 00000077",
                 k, {rsp_valid, cmd_ready, sel}, rsp_rdata);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, cmd_ready, sel} !== 3'b010) begin
      n_errors++;
      $display("FAIL bp_release: {rsp_valid,cmd_ready,sel}=%b required 010",
               {rsp_valid, cmd_ready, sel});
    end
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (sel !== 1'b1 || addr !== 12'h0AB || cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_second_accept: sel=%b addr=%h cmd_ready=%b required 1 0ab 0",
               sel, addr, cmd_ready);
    end
    tick();
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBAD0BAD0) begin
      n_errors++;
      $display("FAIL bp_second_rsp: valid=%b rdata=%h required 1 bad0bad0", rsp_valid, rsp_rdata);
    end
    finish_rsp();
    tick();
    n_checks++;
    if ({sel, cmd_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL bp_single_accept: {sel,cmd_ready}=%b required 01", {sel, cmd_ready});
    end
  endtask

  task automatic test_trap();
    // Read with trap_sel high only in the first select cycle.
    data_to_rd = 32'h0;
    start_cmd(1'b0, 12'hFFF, 32'h0);
    trap_sel = 1'b1;
    tick();
    trap_sel   = 1'b0;
    data_to_rd = 32'h55;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== TRAP_ERR || rsp_rdata !== TRAP_RDATA) begin
      n_errors++;
      $display("FAIL trap_read: valid=%b err=%b rdata=%h required 1 %b %h",
               rsp_valid, rsp_err, rsp_rdata, TRAP_ERR, TRAP_RDATA);
    end
    finish_rsp();
    // Write to an unmapped address still runs its full bus cycle.
    trap_sel = 1'b1;
    start_cmd(1'b1, 12'hFF0, 32'h0BADF00D);
    n_checks++;
    if ({sel, we} !== 2'b11) begin
      n_errors++;
      $display("FAIL trap_write_bus: {sel,we}=%b required 11", {sel, we});
    end
    tick();
    n_checks++;
    if ({sel, we} !== 2'b10) begin
      n_errors++;
      $display("FAIL trap_write_hold: {sel,we}=%b required 10", {sel, we});
    end
    tick();
    trap_sel = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== TRAP_ERR || rsp_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL trap_write_rsp: valid=%b err=%b rdata=%h required 1 %b 0",
               rsp_valid, rsp_err, rsp_rdata, TRAP_ERR);
    end
    finish_rsp();
    // A clean read afterwards must not inherit the trap.
    data_to_rd = 32'h3C;
    start_cmd(1'b0, 12'h020, 32'h0);
    tick();
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h3C) begin
      n_errors++;
      $display("FAIL trap_clear: valid=%b err=%b rdata=%h required 1 0 0000003c",
               rsp_valid, rsp_err, rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid_access();
    start_cmd(1'b1, 12'h044, 32'h00000001);
    n_checks++;
    if (sel !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_precond: sel=%b required 1", sel);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({sel, we, rsp_valid, cmd_ready} !== 4'b0000) begin
      n_errors++;
      $display("FAIL rst_mid_drop: {sel,we,rsp_valid,cmd_ready}=%b required 0000",
               {sel, we, rsp_valid, cmd_ready});
    end
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_checks++;
    if ({cmd_ready, rsp_valid, sel} !== 3'b100) begin
      n_errors++;
      $display("FAIL rst_mid_release: {cmd_ready,rsp_valid,sel}=%b required 100",
               {cmd_ready, rsp_valid, sel});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({rsp_valid, sel} !== 2'b00) begin
        n_errors++;
        $display("FAIL rst_mid_spurious%0d: {rsp_valid,sel}=%b required 00", k, {rsp_valid, sel});
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_backpressure();
    test_trap();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
